fd_bank_chk: RTL and testbench
==============================

FD_BANK_CHK -- requirements
Module: fd_bank_chk

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of flip-flop bits.
REQ-002 SHALL have parameter SETUP, default 2, minimum stable cycles of d before cap.
REQ-003 SHALL have parameter HOLD, default 1, cycles after cap during which d must not change.
REQ-004 SHALL have parameters PMIN / PMAX, defaults 4 / 16, legal cap-to-cap interval in cycles.
REQ-005 SHALL have parameter CNTW, default 8, width of violation counter.
REQ-006 SHALL have parameter VIOL_MODE, default 0: 0 = flag only, 1 = flag and protect q.
REQ-007 SHALL have ports in order: clk in 1 system clock; rst in 1 reset; cap in 1 capture strobe (logical clock edge); d in WIDTH data; clr_n in WIDTH per-bit clear, active low; set_n in WIDTH per-bit set, active low; sticky_clr in 1 clear sticky flags; q out WIDTH register state; setup_viol out 1; hold_viol out 1; period_viol out 1; viol_sticky out 3 {period,hold,setup}; viol_cnt out CNTW.
REQ-008 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-009 SHALL update each q bit on rising clk with priority: set_n=0 -> 1; else clr_n=0 -> 0; else cap=1 -> d; else hold.
REQ-010 SHALL let set override clear when both low on a bit, matching set-dominant behaviour.
REQ-011 SHALL register d into d_prev every cycle; chg = (d != d_prev) on any bit.
REQ-012 SHALL keep stab counter: 0 when chg, else previous+1, saturating at SETUP.
REQ-013 SHALL raise setup_viol for exactly one cycle, in the cycle after cap, when cap occurs with stab < SETUP (chg in the cap cycle counts as stab=0).
REQ-014 SHALL open a hold window of HOLD cycles after each cap; any chg within it SHALL pulse hold_viol one cycle after the change; at most one hold_viol per window.
REQ-015 SHALL restart the hold window on a new cap inside an open window; the closing window is not re-checked.
REQ-016 SHALL count cycles between caps, saturating at PMAX+1; at each cap other than the first after reset, interval < PMIN or > PMAX SHALL pulse period_viol next cycle.
REQ-017 SHALL evaluate all checks regardless of set_n/clr_n state.
REQ-018 VIOL_MODE=1: on setup violation, bits not forced by set/clr SHALL keep their old value instead of capturing d.
REQ-019 VIOL_MODE=1: on hold violation, bits not currently forced by set/clr SHALL revert to the pre-capture value (shadow register of q before the last cap).
REQ-020 SHALL OR each violation pulse into viol_sticky; sticky_clr clears it; a new violation in the same cycle as sticky_clr SHALL leave that bit set.
REQ-021 SHALL add the number of violation pulses in a cycle (0-3) to viol_cnt, saturating at all-ones, never wrapping.

Reset
REQ-022 On rst: q=0, d_prev=0, stab=0, hold window closed, interval counter 0, first-cap flag set, shadow=0, all violation outputs and viol_cnt = 0.
REQ-023 rst SHALL override set_n, clr_n and cap in the same cycle; rst mid-hold-window SHALL cancel the window without a flag.

Verification
REQ-024 set_n=0 and clr_n=0 on bit 3, cap=1, d=0 -> q[3]=1 next cycle; other bits take d.
REQ-025 d changes at cycle 10, cap at cycle 11 (SETUP=2) -> setup_viol=1 at cycle 12, viol_cnt=1; VIOL_MODE=1 -> q unchanged.
REQ-026 cap at cycle 20 with d stable 5 cycles, d changes at cycle 21 (HOLD=1) -> hold_viol=1 at cycle 22; VIOL_MODE=1 -> q back to pre-cap value.
REQ-027 caps at cycles 0, 3, 20 (PMIN=4, PMAX=16) -> no flag for first cap, period_viol after cap 2 and after cap 3, viol_sticky[2]=1.
REQ-028 viol_cnt preloaded near all-ones via repeated violations, sticky_clr coincident with new setup violation -> viol_cnt stays all-ones, viol_sticky[0] remains 1.
REQ-029 rst asserted during open hold window with d changing -> no hold_viol, all outputs 0 next cycle.

Source files
------------

// File: rtl/fd_bank_chk.sv
// Flip-flop bank with per-bit set/clear and timing checks (setup, hold, cap period).
// Violations are pulsed, accumulated in sticky flags and counted; VIOL_MODE=1 also protects q.
module fd_bank_chk #(
  parameter int WIDTH     = 8,
  parameter int SETUP     = 2,
  parameter int HOLD      = 1,
  parameter int PMIN      = 4,
  parameter int PMAX      = 16,
  parameter int CNTW      = 8,
  parameter int VIOL_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] clr_n,
  input  logic [WIDTH-1:0] set_n,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] q,
  output logic             setup_viol,
  output logic             hold_viol,
  output logic             period_viol,
  output logic [2:0]       viol_sticky,
  output logic [CNTW-1:0]  viol_cnt
);

  localparam int STW = $clog2(SETUP + 2);
  localparam int HW  = $clog2(HOLD + 2);
  localparam int IW  = $clog2(PMAX + 2);
  localparam logic [STW-1:0] STAB_MAX = STW'(SETUP);
  localparam logic [HW-1:0]  HOLD_LD  = HW'(HOLD);
  localparam logic [IW-1:0]  IVAL_MAX = IW'(PMAX + 1);

  function automatic logic [STW-1:0] f_stab_next(input logic [STW-1:0] s);
    return (s >= STAB_MAX) ? s : s + STW'(1);
  endfunction

  function automatic logic [IW-1:0] f_ival_next(input logic [IW-1:0] v);
    return (v >= IVAL_MAX) ? v : v + IW'(1);
  endfunction

  function automatic logic [CNTW-1:0] f_cnt_add(input logic [CNTW-1:0] c, input logic [1:0] n);
    logic [CNTW:0] s;
    s = {1'b0, c} + (CNTW+1)'(n);
    return s[CNTW] ? '1 : s[CNTW-1:0];
  endfunction

  logic [WIDTH-1:0] r_q, r_d_prev, r_shadow;
  logic [STW-1:0]   r_stab;
  logic [HW-1:0]    r_hold_cnt;
  logic             r_hold_flag;
  logic [IW-1:0]    r_ival;
  logic             r_first;
  logic             r_setup_viol_p1, r_hold_viol_p1, r_period_viol_p1;
  logic [2:0]       r_sticky;
  logic [CNTW-1:0]  r_cnt;

  logic             w_chg, w_setup_v, w_hold_v, w_period_v;
  logic             w_revert, w_capture;
  logic [STW-1:0]   w_stab_eff;
  logic [1:0]       w_nviol;
  logic [WIDTH-1:0] w_q_next;

  // Stage p0: check evaluation on the current inputs
  assign w_chg      = (d != r_d_prev);
  assign w_stab_eff = w_chg ? '0 : r_stab;
  assign w_setup_v  = cap && (int'(w_stab_eff) < SETUP);
  // A cap cycle closes the old window unchecked; its change is judged as setup.
  assign w_hold_v   = !cap && w_chg && (r_hold_cnt != '0) && !r_hold_flag;
  assign w_period_v = cap && !r_first && ((int'(r_ival) < PMIN) || (int'(r_ival) > PMAX));
  assign w_nviol    = {1'b0, w_setup_v} + {1'b0, w_hold_v} + {1'b0, w_period_v};

  assign w_revert  = (VIOL_MODE == 1) && w_hold_v;
  assign w_capture = cap && !((VIOL_MODE == 1) && w_setup_v);

  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!set_n[i])      w_q_next[i] = 1'b1;
      else if (!clr_n[i]) w_q_next[i] = 1'b0;
      else if (w_revert)  w_q_next[i] = r_shadow[i];
      else if (w_capture) w_q_next[i] = d[i];
    end
  end

  // Stage p1: state update and registered violation pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q              <= '0;
      r_d_prev         <= '0;
      r_shadow         <= '0;
      r_stab           <= '0;
      r_hold_cnt       <= '0;
      r_hold_flag      <= 1'b0;
      r_ival           <= '0;
      r_first          <= 1'b1;
      r_setup_viol_p1  <= 1'b0;
      r_hold_viol_p1   <= 1'b0;
      r_period_viol_p1 <= 1'b0;
      r_sticky         <= '0;
      r_cnt            <= '0;
    end else begin
      r_q      <= w_q_next;
      r_d_prev <= d;
      r_stab   <= w_chg ? '0 : f_stab_next(r_stab);
      if (cap) begin
        r_shadow    <= r_q;
        r_hold_cnt  <= HOLD_LD;
        r_hold_flag <= 1'b0;
        r_ival      <= IW'(1);
        r_first     <= 1'b0;
      end else begin
        if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - HW'(1);
        if (w_hold_v) r_hold_flag <= 1'b1;
        r_ival <= f_ival_next(r_ival);
      end
      r_setup_viol_p1  <= w_setup_v;
      r_hold_viol_p1   <= w_hold_v;
      r_period_viol_p1 <= w_period_v;
      r_sticky         <= (sticky_clr ? 3'b000 : r_sticky) | {w_period_v, w_hold_v, w_setup_v};
      r_cnt            <= f_cnt_add(r_cnt, w_nviol);
    end
  end

  assign q           = r_q;
  assign setup_viol  = r_setup_viol_p1;
  assign hold_viol   = r_hold_viol_p1;
  assign period_viol = r_period_viol_p1;
  assign viol_sticky = r_sticky;
  assign viol_cnt    = r_cnt;

endmodule

// File: tb/tb_fd_bank_chk.sv
// Scoreboard bench for fd_bank_chk: two instances (VIOL_MODE 0 and 1) share stimulus and are
// compared every cycle against a cycle-indexed behavioural model, plus fixed-value scenario checks.
module tb_fd_bank_chk;
  localparam int W = 8, SETUP = 2, HOLD = 1, PMIN = 4, PMAX = 16, CNTW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cap, sticky_clr;
  logic [W-1:0] d, clr_n, set_n;
  logic [W-1:0] q0, q1;
  logic sv0, hv0, pv0, sv1, hv1, pv1;
  logic [2:0] vs0, vs1;
  logic [CNTW-1:0] c0, c1;
  logic [21:0] o0, o1;
  assign o0 = {q0, sv0, hv0, pv0, vs0, c0};
  assign o1 = {q1, sv1, hv1, pv1, vs1, c1};

  fd_bank_chk #(.WIDTH(W), .SETUP(SETUP), .HOLD(HOLD), .PMIN(PMIN), .PMAX(PMAX), .CNTW(CNTW), .VIOL_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .cap(cap), .d(d), .clr_n(clr_n), .set_n(set_n), .sticky_clr(sticky_clr),
    .q(q0), .setup_viol(sv0), .hold_viol(hv0), .period_viol(pv0), .viol_sticky(vs0), .viol_cnt(c0));
  fd_bank_chk #(.WIDTH(W), .SETUP(SETUP), .HOLD(HOLD), .PMIN(PMIN), .PMAX(PMAX), .CNTW(CNTW), .VIOL_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .cap(cap), .d(d), .clr_n(clr_n), .set_n(set_n), .sticky_clr(sticky_clr),
    .q(q1), .setup_viol(sv1), .hold_viol(hv1), .period_viol(pv1), .viol_sticky(vs1), .viol_cnt(c1));

  typedef struct { logic r; logic c; logic [7:0] d; logic [7:0] cn; logic [7:0] sn; logic sc; } stim_t;
  typedef struct { logic [21:0] e0; logic [21:0] e1; } exp_t;
  exp_t sb[$];
  int n_pass = 0, n_tot = 0;

  // Model state expressed in cycle numbers: last change, last cap, last window cycle.
  logic [7:0] m_q[2], m_sh[2], m_dprev;
  int t = 0, m_lchg, m_lcap, m_wend, m_cnt;
  logic m_first, m_wflag;
  logic [2:0] m_st;

  function automatic stim_t mk(logic r, logic c, logic [7:0] dd, logic [7:0] cn, logic [7:0] sn, logic sc);
    stim_t s;
    s.r = r; s.c = c; s.d = dd; s.cn = cn; s.sn = sn; s.sc = sc;
    return s;
  endfunction
  function automatic stim_t rstp();           return mk(1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0); endfunction
  function automatic stim_t idle(logic [7:0] dd); return mk(1'b0, 1'b0, dd, 8'hFF, 8'hFF, 1'b0); endfunction
  function automatic stim_t capd(logic [7:0] dd); return mk(1'b0, 1'b1, dd, 8'hFF, 8'hFF, 1'b0); endfunction

  task automatic cyc(input stim_t s);
    logic chg, sv, hv, pv;
    logic [7:0] nq;
    int n;
    exp_t e;
    rst = s.r; cap = s.c; d = s.d; clr_n = s.cn; set_n = s.sn; sticky_clr = s.sc;
    sv = 1'b0; hv = 1'b0; pv = 1'b0;
    if (s.r) begin
      m_q[0] = 8'h00; m_q[1] = 8'h00; m_sh[0] = 8'h00; m_sh[1] = 8'h00; m_dprev = 8'h00;
      m_lchg = t; m_lcap = 0; m_wend = -1; m_wflag = 1'b0; m_first = 1'b1; m_st = 3'b000; m_cnt = 0;
    end else begin
      chg = (s.d != m_dprev);
      if (chg) m_lchg = t;
      sv = s.c && (t - m_lchg - 1 < SETUP);
      hv = !s.c && chg && (t <= m_wend) && !m_wflag;
      if (hv) m_wflag = 1'b1;
      pv = s.c && !m_first && ((t - m_lcap < PMIN) || (t - m_lcap > PMAX));
      for (int k = 0; k < 2; k++) begin
        for (int b = 0; b < 8; b++) begin
          if (!s.sn[b])                   nq[b] = 1'b1;
          else if (!s.cn[b])              nq[b] = 1'b0;
          else if (k == 1 && hv)          nq[b] = m_sh[k][b];
          else if (s.c && !(k == 1 && sv)) nq[b] = s.d[b];
          else                            nq[b] = m_q[k][b];
        end
        if (s.c) m_sh[k] = m_q[k];
        m_q[k] = nq;
      end
      if (s.c) begin m_lcap = t; m_first = 1'b0; m_wend = t + HOLD; m_wflag = 1'b0; end
      m_st = (s.sc ? 3'b000 : m_st) | {pv, hv, sv};
      n = m_cnt + int'(sv) + int'(hv) + int'(pv);
      m_cnt = (n > 255) ? 255 : n;
      m_dprev = s.d;
    end
    e.e0 = {m_q[0], sv, hv, pv, m_st, 8'(m_cnt)};
    e.e1 = {m_q[1], sv, hv, pv, m_st, 8'(m_cnt)};
    sb.push_back(e);
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t st[$]; logic [21:0] ob0[$], ob1[$]; exp_t e; logic [21:0] x0, x1;
    for (int i = 0; i < 3; i++)
      st.push_back(mk(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom)));
    foreach (st[i]) begin
      cyc(st[i]); e = sb.pop_front(); n_tot++;
      if (o0 !== e.e0 || o1 !== e.e1)
        $display("FAIL reset_seq step=%0d dut0=%h exp0=%h dut1=%h exp1=%h", i, o0, e.e0, o1, e.e1);
      else n_pass++;
      ob0.push_back(o0); ob1.push_back(o1);
    end
    x0 = ob0[2]; x1 = ob1[2];
    n_tot++;
    if (x0 !== 22'h0 || x1 !== 22'h0) $display("FAIL reset_zero got=%h/%h exp=000000", x0, x1);
    else n_pass++;
  endtask

  task automatic test_set_dominant();
    stim_t st[$]; logic [21:0] ob0[$], ob1[$]; exp_t e; logic [21:0] x0, x1;
    st.push_back(rstp());
    for (int i = 0; i < 3; i++) st.push_back(idle(8'hF0));
    st.push_back(capd(8'hF0));
    st.push_back(idle(8'hF0));
    for (int i = 0; i < 3; i++) st.push_back(idle(8'h00));
    st.push_back(mk(1'b0, 1'b1, 8'h00, 8'hF7, 8'hF7, 1'b0));
    foreach (st[i]) begin
      cyc(st[i]); e = sb.pop_front(); n_tot++;
      if (o0 !== e.e0 || o1 !== e.e1)
        $display("FAIL set_dom_seq step=%0d dut0=%h exp0=%h dut1=%h exp1=%h", i, o0, e.e0, o1, e.e1);
      else n_pass++;
      ob0.push_back(o0); ob1.push_back(o1);
    end
    x0 = ob0[4]; x1 = ob1[4];
    n_tot++;
    if (x0[21:14] !== 8'hF0 || x1[21:14] !== 8'hF0) $display("FAIL cap_load q got=%h/%h exp=f0", x0[21:14], x1[21:14]);
    else n_pass++;
    x0 = ob0[9]; x1 = ob1[9];
    n_tot++;
    if (x0[21:14] !== 8'h08 || x1[21:14] !== 8'h08) $display("FAIL set_dominant q got=%h/%h exp=08", x0[21:14], x1[21:14]);
    else n_pass++;
  endtask

  task automatic test_setup();
    stim_t st[$]; logic [21:0] ob0[$], ob1[$]; exp_t e; logic [21:0] x0, x1;
    st.push_back(rstp());
    for (int i = 0; i < 4; i++) st.push_back(idle(8'h11));
    st.push_back(capd(8'h11));
    for (int i = 0; i < 4; i++) st.push_back(idle(8'h11));
    st.push_back(idle(8'h22));
    st.push_back(capd(8'h22));
    foreach (st[i]) begin
      cyc(st[i]); e = sb.pop_front(); n_tot++;
      if (o0 !== e.e0 || o1 !== e.e1)
        $display("FAIL setup_seq step=%0d dut0=%h exp0=%h dut1=%h exp1=%h", i, o0, e.e0, o1, e.e1);
      else n_pass++;
      ob0.push_back(o0); ob1.push_back(o1);
    end
    x0 = ob0[11]; x1 = ob1[11];
    n_tot++;
    if (x0[13] !== 1'b1 || x1[13] !== 1'b1 || x0[7:0] !== 8'd1 || x1[7:0] !== 8'd1)
      $display("FAIL setup_flag sv=%b/%b cnt=%0d/%0d exp sv=1 cnt=1", x0[13], x1[13], x0[7:0], x1[7:0]);
    else n_pass++;
    n_tot++;
    if (x0[21:14] !== 8'h22 || x1[21:14] !== 8'h11)
      $display("FAIL setup_protect q got=%h/%h exp=22/11", x0[21:14], x1[21:14]);
    else n_pass++;
  endtask

  task automatic test_hold();
    stim_t st[$]; logic [21:0] ob0[$], ob1[$]; exp_t e; logic [21:0] x0, x1;
    st.push_back(rstp());
    for (int i = 0; i < 4; i++) st.push_back(idle(8'h3C));
    st.push_back(capd(8'h3C));
    for (int i = 0; i < 4; i++) st.push_back(idle(8'h3C));
    for (int i = 0; i < 5; i++) st.push_back(idle(8'hC3));
    st.push_back(capd(8'hC3));
    st.push_back(idle(8'h5A));
    foreach (st[i]) begin
      cyc(st[i]); e = sb.pop_front(); n_tot++;
      if (o0 !== e.e0 || o1 !== e.e1)
        $display("FAIL hold_seq step=%0d dut0=%h exp0=%h dut1=%h exp1=%h", i, o0, e.e0, o1, e.e1);
      else n_pass++;
      ob0.push_back(o0); ob1.push_back(o1);
    end
    x0 = ob0[16]; x1 = ob1[16];
    n_tot++;
    if (x0[12] !== 1'b1 || x1[12] !== 1'b1 || x0[13] !== 1'b0)
      $display("FAIL hold_flag hv=%b/%b sv=%b exp hv=1 sv=0", x0[12], x1[12], x0[13]);
    else n_pass++;
    n_tot++;
    if (x0[21:14] !== 8'hC3 || x1[21:14] !== 8'h3C)
      $display("FAIL hold_revert q got=%h/%h exp=c3/3c", x0[21:14], x1[21:14]);
    else n_pass++;
  endtask

  task automatic test_period();
    stim_t st[$]; logic [21:0] ob0[$], ob1[$]; exp_t e; logic [21:0] x0;
    st.push_back(rstp());
    for (int i = 0; i < 3; i++) st.push_back(idle(8'h77));
    st.push_back(capd(8'h77));
    for (int i = 0; i < 2; i++) st.push_back(idle(8'h77));
    st.push_back(capd(8'h77));
    for (int i = 0; i < 16; i++) st.push_back(idle(8'h77));
    st.push_back(capd(8'h77));
    foreach (st[i]) begin
      cyc(st[i]); e = sb.pop_front(); n_tot++;
      if (o0 !== e.e0 || o1 !== e.e1)
        $display("FAIL period_seq step=%0d dut0=%h exp0=%h dut1=%h exp1=%h", i, o0, e.e0, o1, e.e1);
      else n_pass++;
      ob0.push_back(o0); ob1.push_back(o1);
    end
    x0 = ob0[4];
    n_tot++;
    if (x0[11] !== 1'b0) $display("FAIL period_first pv got=%b exp=0", x0[11]);
    else n_pass++;
    x0 = ob0[7];
    n_tot++;
    if (x0[11] !== 1'b1) $display("FAIL period_short pv got=%b exp=1", x0[11]);
    else n_pass++;
    x0 = ob0[24];
    n_tot++;
    if (x0[11] !== 1'b1 || x0[10] !== 1'b1) $display("FAIL period_long pv=%b sticky2=%b exp=1/1", x0[11], x0[10]);
    else n_pass++;
  endtask

  task automatic test_cnt_sat();
    stim_t st[$]; logic [21:0] ob0[$], ob1[$]; exp_t e; logic [21:0] x0, x1;
    st.push_back(rstp());
    for (int i = 0; i < 135; i++) st.push_back(capd((i % 2 == 0) ? 8'hFF : 8'h00));
    st.push_back(mk(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1));
    foreach (st[i]) begin
      cyc(st[i]); e = sb.pop_front(); n_tot++;
      if (o0 !== e.e0 || o1 !== e.e1)
        $display("FAIL cnt_seq step=%0d dut0=%h exp0=%h dut1=%h exp1=%h", i, o0, e.e0, o1, e.e1);
      else n_pass++;
      ob0.push_back(o0); ob1.push_back(o1);
    end
    x0 = ob0[11];
    n_tot++;
    if (x0[7:0] !== 8'd21) $display("FAIL cnt_accum got=%0d exp=21", x0[7:0]);
    else n_pass++;
    x0 = ob0[127];
    n_tot++;
    if (x0[7:0] !== 8'd253) $display("FAIL cnt_near_max got=%0d exp=253", x0[7:0]);
    else n_pass++;
    x0 = ob0[136]; x1 = ob1[136];
    n_tot++;
    if (x0[7:0] !== 8'hFF || x1[7:0] !== 8'hFF) $display("FAIL cnt_saturate got=%h/%h exp=ff", x0[7:0], x1[7:0]);
    else n_pass++;
    n_tot++;
    if (x0[8] !== 1'b1 || x0[10:8] !== 3'b101) $display("FAIL sticky_vs_clr got=%b exp=101", x0[10:8]);
    else n_pass++;
  endtask

  task automatic test_rst_window();
    stim_t st[$]; logic [21:0] ob0[$], ob1[$]; exp_t e; logic [21:0] x0, x1;
    st.push_back(rstp());
    for (int i = 0; i < 3; i++) st.push_back(idle(8'hAA));
    st.push_back(capd(8'hAA));
    st.push_back(mk(1'b1, 1'b0, 8'h55, 8'hFF, 8'hFF, 1'b0));
    st.push_back(idle(8'h55));
    foreach (st[i]) begin
      cyc(st[i]); e = sb.pop_front(); n_tot++;
      if (o0 !== e.e0 || o1 !== e.e1)
        $display("FAIL rst_win_seq step=%0d dut0=%h exp0=%h dut1=%h exp1=%h", i, o0, e.e0, o1, e.e1);
      else n_pass++;
      ob0.push_back(o0); ob1.push_back(o1);
    end
    x0 = ob0[4];
    n_tot++;
    if (x0[21:14] !== 8'hAA) $display("FAIL rst_win_load q got=%h exp=aa", x0[21:14]);
    else n_pass++;
    x0 = ob0[5]; x1 = ob1[5];
    n_tot++;
    if (x0 !== 22'h0 || x1 !== 22'h0) $display("FAIL rst_in_window got=%h/%h exp=000000", x0, x1);
    else n_pass++;
    x0 = ob0[6]; x1 = ob1[6];
    n_tot++;
    if (x0 !== 22'h0 || x1 !== 22'h0) $display("FAIL rst_window_closed got=%h/%h exp=000000", x0, x1);
    else n_pass++;
  endtask

  task automatic test_random();
    stim_t st[$]; exp_t e; logic [7:0] dcur;
    dcur = 8'h00;
    st.push_back(rstp());
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) dcur = 8'($urandom);
      st.push_back(mk($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0, dcur,
                      ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF,
                      ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF,
                      $urandom_range(0, 9) == 0));
    end
    foreach (st[i]) begin
      cyc(st[i]); e = sb.pop_front(); n_tot++;
      if (o0 !== e.e0 || o1 !== e.e1)
        $display("FAIL random step=%0d dut0=%h exp0=%h dut1=%h exp1=%h", i, o0, e.e0, o1, e.e1);
      else n_pass++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_tot);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cap = 1'b0; d = '0; clr_n = '1; set_n = '1; sticky_clr = 1'b0;
    test_reset();
    test_set_dominant();
    test_setup();
    test_hold();
    test_period();
    test_cnt_sat();
    test_rst_window();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
